// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all reset domains after a reset event, then releases
// them one at a time (bit 0 first) with a fixed stagger and reports completion.
// One saturating counter times the hold, the stagger and, when the optional
// watchdog is built in (macro RESET_SEQUENCER_WDT_EN), the watchdog timeout.
// rst_cause records whether the last reset came from power-on, software or
// the watchdog.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 30,
  parameter int STAGGER     = 4,
  parameter int NUM_DOMAINS = 3,
  parameter int WDT_CYCLES  = 30000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   por_done,
  output logic [1:0]             rst_cause
);

  localparam int MAX_HS  = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int MAX_CNT = (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

  localparam logic [NUM_DOMAINS-1:0] DOM_LSB = NUM_DOMAINS'(1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RELEASE = 2'b01,
    RUN     = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   por_d;
  logic [1:0]             cause_d;

  // Counter never wraps: it sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

`ifdef RESET_SEQUENCER_WDT_EN
  // Expiry fires on the edge where the count since the last kick (or RUN
  // entry) reaches WDT_CYCLES-1, i.e. when the registered count is one below.
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 2);
  logic wdt_fire;
`else
  // The watchdog is not built; the kick input is deliberately left unused.
  logic unused_kick;
  assign unused_kick = wdt_kick;
`endif

  // Next-state, counter and registered-output values for the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_rst_n;
    por_d   = por_done;
    cause_d = rst_cause;
`ifdef RESET_SEQUENCER_WDT_EN
    wdt_fire = 1'b0;
`endif
    case (state_q)
      HOLD: begin
        dom_d = '0;
        por_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          dom_d = DOM_LSB;
          if (NUM_DOMAINS == 1) begin
            state_d = RUN;
            por_d   = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          cnt_d = '0;
          dom_d = (dom_rst_n << 1) | DOM_LSB;
          if (&dom_d) begin
            state_d = RUN;
            por_d   = 1'b1;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RUN: begin
`ifdef RESET_SEQUENCER_WDT_EN
        if (wdt_kick) begin
          cnt_d = '0;
        end else if (cnt_q == WDT_LAST) begin
          wdt_fire = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
`else
        cnt_d = cnt_q;
`endif
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        dom_d   = '0;
        por_d   = 1'b0;
      end
    endcase

    // Software request wins over everything except rst_n, including expiry.
    if (sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      dom_d   = '0;
      por_d   = 1'b0;
      cause_d = CAUSE_SW;
    end
`ifdef RESET_SEQUENCER_WDT_EN
    else if (wdt_fire) begin
      state_d = HOLD;
      cnt_d   = '0;
      dom_d   = '0;
      por_d   = 1'b0;
      cause_d = CAUSE_WDT;
    end
`endif
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      dom_rst_n <= '0;
      por_done  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dom_rst_n <= dom_d;
      por_done  <= por_d;
      rst_cause <= cause_d;
    end
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 30: cycles all domains stay in reset after a reset event; legal range 1..65535.
REQ-002 The block SHALL have parameter STAGGER, default 4: cycles between successive domain releases; legal range 1..255.
REQ-003 The block SHALL have parameter NUM_DOMAINS, default 3: number of reset domains; legal range 1..8.
REQ-004 The block SHALL have parameter WDT_CYCLES, default 30000: watchdog timeout in cycles; legal range 2..2^24-1.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 sw_rst_req  input  1  software reset request, level sampled each cycle.
REQ-008 wdt_kick  input  1  watchdog service strobe; the port is present in every build.
REQ-009 dom_rst_n  output  NUM_DOMAINS  per-domain active-low resets, registered; bit 0 releases first.
REQ-010 por_done  output  1  high when all domains are released, registered.
REQ-011 rst_cause  output  2  cause of last reset: 00 power-on, 01 software, 10 watchdog; 11 never driven.

Function
REQ-012 The FSM SHALL have states HOLD, RELEASE and RUN; one cycle counter SHALL serve HOLD, RELEASE and the watchdog.
REQ-013 HOLD: dom_rst_n all 0, por_done 0; the counter increments each cycle; at count HOLD_CYCLES-1 the FSM SHALL go to RELEASE and set dom_rst_n[0] to 1 on the same edge.
REQ-014 RELEASE: every STAGGER cycles the next dom_rst_n bit SHALL go to 1; released bits stay 1.
REQ-015 On the edge that releases bit NUM_DOMAINS-1 the FSM SHALL enter RUN and por_done SHALL go to 1.
REQ-016 Timing, counting the first rising edge with rst_n=1 as edge 1: dom_rst_n[i] rises at edge HOLD_CYCLES+i*STAGGER. Defaults give edges 30, 34 and 38.
REQ-017 NUM_DOMAINS=1: HOLD goes directly to RUN; dom_rst_n[0] and por_done rise on the same edge.
REQ-018 sw_rst_req=1 on any edge in any state SHALL do all of the following on that edge: set dom_rst_n to 0, clear por_done, clear the counter, enter HOLD, set rst_cause=01.
REQ-019 sw_rst_req held high SHALL keep the block in HOLD with the counter at 0; the sequence restarts from the first edge after it deasserts.
REQ-020 rst_cause SHALL hold its value until the next reset event.
REQ-021 The counter SHALL saturate and never wrap. Its width SHALL cover max(HOLD_CYCLES, STAGGER, WDT_CYCLES).

Reset
REQ-022 rst_n=0 at a rising edge SHALL force HOLD, counter 0, dom_rst_n all 0, por_done 0 and rst_cause 00, overriding all other inputs.
REQ-023 rst_n asserted mid-sequence or in RUN SHALL abort immediately; the full sequence SHALL restart after release.
REQ-024 No output SHALL change except on a rising clk edge; there SHALL be no asynchronous reset path.

Configuration
REQ-025 Macro RESET_SEQUENCER_WDT_EN SHALL control the watchdog; its effect is defined by REQ-026 to REQ-029.
REQ-026 With the macro defined, in RUN the counter SHALL increment each cycle. wdt_kick=1 SHALL clear it to 0 on that edge.
REQ-027 With the macro defined, reaching WDT_CYCLES-1 without a kick SHALL act as REQ-018 but set rst_cause=10.
REQ-028 With the macro defined, priorities on the same edge SHALL be: kick beats expiry (no reset), and sw_rst_req beats expiry (rst_cause=01).
REQ-029 Without the macro, wdt_kick SHALL be ignored, no watchdog logic SHALL be synthesized, RUN SHALL persist indefinitely, and rst_cause SHALL never be 10.

Verification
REQ-030 Defaults, rst_n low 30 cycles then high -> dom_rst_n 000 to 001 at edge 30, 011 at edge 34, 111 at edge 38; por_done rises at edge 38; rst_cause 00.
REQ-031 In RUN, sw_rst_req pulsed for 1 cycle -> on that edge dom_rst_n=000, por_done=0, rst_cause=01; full release 38 edges after the pulse edge.
REQ-032 sw_rst_req pulse at edge 32 (domain 0 already released) -> dom_rst_n=000 at edge 32, restart; rst_cause=01.
REQ-033 rst_n driven low at edge 35 -> edge 35 gives dom_rst_n=000, rst_cause=00; the sequence restarts after release.
REQ-034 With the macro, WDT_CYCLES=100: kick every 50 cycles -> no reset over 1000 cycles; stop kicking -> reset 99 edges after the last kick edge with rst_cause=10. Kick on the expiry edge -> no reset.
REQ-035 Without the macro, run 40000 cycles in RUN with no kicks -> por_done stays 1 and rst_cause is never 10.
